// File: rtl/usr_shift_sequencer_if.sv
// usr_shift_sequencer_if
//   Bus bundle for the universal shift sequencer.
//   Ports (from the master side):
//     OP[2:0]        operation select
//     D[0:WIDTH-1]   parallel load data, bit 0 is the MSB/sign
//     S0, SN         serial inputs for SHR / SHL
//     START, CNT     begin a multi-step run of OP for CNT steps
//     ABORT          terminate a run in progress
//     Q, SOUT        register contents and last shifted-out bit
//     BUSY, DONE     run in progress / one-cycle end-of-run pulse
//     dbg_state      sequencer state (0 = IDLE, 1 = RUN)
//   Handshake: START is sampled only while the sequencer is IDLE (including
//   the DONE cycle); while BUSY is high, OP/D/START/CNT are ignored and only
//   ABORT, S0 and SN are observed. DONE marks completion of a run for one cycle.
interface usr_shift_sequencer_if #(
    parameter int WIDTH = 36,
    parameter int CW    = 6
);
    logic [2:0]       OP;
    logic [0:WIDTH-1] D;
    logic             S0;
    logic             SN;
    logic             START;
    logic [CW-1:0]    CNT;
    logic             ABORT;
    logic [0:WIDTH-1] Q;
    logic             SOUT;
    logic             BUSY;
    logic             DONE;
    logic             dbg_state;

    modport master (
        output OP, D, S0, SN, START, CNT, ABORT,
        input  Q, SOUT, BUSY, DONE, dbg_state
    );

    modport slave (
        input  OP, D, S0, SN, START, CNT, ABORT,
        output Q, SOUT, BUSY, DONE, dbg_state
    );
endinterface

// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer
//   Universal shift register with a built-in shift-count sequencer.
//   Single-step ops (load/shift/rotate/arith-shift/hold) execute once per
//   clock in IDLE; START with a shift/rotate op runs CNT one-bit steps.
//   Ports:
//     CLK    clock, all state updates on posedge
//     RESET  asynchronous, active-high reset
//     bus    usr_shift_sequencer_if.slave (OP, D, S0, SN, START, CNT, ABORT,
//            Q, SOUT, BUSY, DONE, dbg_state)
//   Bit numbering is [0:WIDTH-1] with bit 0 the MSB/sign bit.
module usr_shift_sequencer #(
    parameter int WIDTH = 36,
    parameter int CW    = 6
) (
    input  logic                  CLK,
    input  logic                  RESET,
    usr_shift_sequencer_if.slave  bus
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_HOLD = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;
    localparam logic [2:0] OP_ROTL = 3'b101;
    localparam logic [2:0] OP_ASHR = 3'b110;
    localparam logic [2:0] OP_ASHL = 3'b111;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state;
    logic [0:WIDTH-1] q_r;
    logic             sout_r;
    logic             busy_r;
    logic             done_r;
    logic [CW-1:0]    rem_r;
    logic [2:0]       run_op_r;

    logic [2:0]       step_op;
    logic [0:WIDTH-1] step_q;
    logic             step_sout;
    logic             start_ok;

    // In RUN the latched op drives the step; in IDLE the live OP does.
    assign step_op  = (state == S_RUN) ? run_op_r : bus.OP;
    assign start_ok = bus.START && (bus.OP != OP_LOAD) && (bus.OP != OP_HOLD);

    // One-bit step result for the selected op; LOAD/HOLD keep SOUT.
    always_comb begin
        step_q    = q_r;
        step_sout = sout_r;
        case (step_op)
            OP_LOAD: step_q = bus.D;
            OP_SHR: begin
                step_q    = {bus.S0, q_r[0:WIDTH-2]};
                step_sout = q_r[WIDTH-1];
            end
            OP_SHL: begin
                step_q    = {q_r[1:WIDTH-1], bus.SN};
                step_sout = q_r[0];
            end
            OP_ROTR: begin
                step_q    = {q_r[WIDTH-1], q_r[0:WIDTH-2]};
                step_sout = q_r[WIDTH-1];
            end
            OP_ROTL: begin
                step_q    = {q_r[1:WIDTH-1], q_r[0]};
                step_sout = q_r[0];
            end
            OP_ASHR: begin
                step_q    = {q_r[0], q_r[0:WIDTH-2]};
                step_sout = q_r[WIDTH-1];
            end
            OP_ASHL: begin
                // Sign bit stays put; magnitude bits move toward it.
                step_q    = {q_r[0], q_r[2:WIDTH-1], 1'b0};
                step_sout = q_r[1];
            end
            default: begin
                step_q    = q_r;
                step_sout = sout_r;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            q_r      <= '0;
            sout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            rem_r    <= '0;
            run_op_r <= OP_HOLD;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    q_r    <= step_q;
                    sout_r <= step_sout;
                    if (start_ok) begin
                        run_op_r <= bus.OP;
                        if (bus.CNT == '0) begin
                            // Zero-length run: no step, just report completion.
                            q_r    <= q_r;
                            sout_r <= sout_r;
                            done_r <= 1'b1;
                        end else if (bus.CNT == CW'(1)) begin
                            done_r <= 1'b1;
                        end else begin
                            // First step happens on this edge, so n-1 remain.
                            rem_r  <= bus.CNT - CW'(1);
                            state  <= S_RUN;
                            busy_r <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.ABORT) begin
                        state  <= S_IDLE;
                        rem_r  <= '0;
                        busy_r <= 1'b0;
                    end else begin
                        q_r    <= step_q;
                        sout_r <= step_sout;
                        rem_r  <= rem_r - CW'(1);
                        if (rem_r == CW'(1)) begin
                            state  <= S_IDLE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q         = q_r;
    assign bus.SOUT      = sout_r;
    assign bus.BUSY      = busy_r;
    assign bus.DONE      = done_r;
    assign bus.dbg_state = (state == S_RUN);

endmodule
